hazard_control_unit: RTL and testbench
======================================

// Module: hazard_control_unit
// PURPOSE
//  Pipeline sequencer for the 5-stage core, companion to the forwarding logic.
//  Handles the cases forwarding cannot cover: load-use hazards (1-cycle stall + bubble),
//  taken-branch squash (branch resolved in EX), and data-memory wait (whole-pipe freeze).
//  Also provides a post-reset hold cycle, saturating stall/flush counters and a sticky memory-timeout flag.
// PARAMETERS
//  REG_W         5    register-address width (IFID_Rs/Rt, IDEX_Rt)
//  CNT_W         16   width of stall_cnt / flush_cnt; saturate at all-ones
//  WAIT_TIMEOUT  64   consecutive MEM_WAIT cycles that set mem_timeout (>=1)
// PORTS
//  clk            in   1      core clock, rising edge
//  rst_n          in   1      asynchronous active-low reset
//  IFID_Rs        in   REG_W  rs of the instruction in ID
//  IFID_Rt        in   REG_W  rt of the instruction in ID
//  IFID_UsesRt    in   1      ID instruction reads rt (R-type, store, beq/bne)
//  IDEX_Rt        in   REG_W  destination rt of the instruction in EX
//  IDEX_MemRead   in   1      instruction in EX is a load
//  EX_BranchTaken in   1      branch in EX is resolved taken this cycle
//  MEM_Req        in   1      data-memory access in MEM this cycle
//  MEM_Ready      in   1      data memory completes the access this cycle
//  PCWrite        out  1      PC update enable
//  IFID_Write     out  1      IF/ID register write enable
//  IFID_Flush     out  1      load NOP into IF/ID
//  IDEX_Bubble    out  1      zero control fields written into ID/EX
//  PipeFreeze     out  1      hold ID/EX, EX/MEM, MEM/WB
//  hz_action      out  3      current-cycle action (combinational)
//  hz_state       out  3      registered action of the previous cycle
//  stall_cnt      out  CNT_W  cycles spent in LU_STALL or MEM_WAIT
//  flush_cnt      out  CNT_W  cycles spent in FLUSH
//  mem_timeout    out  1      sticky; set when a memory wait reaches WAIT_TIMEOUT
// BEHAVIOUR
//  Action encoding: INIT=0, RUN=1, LU_STALL=2, FLUSH=3, MEM_WAIT=4.
//  Registers: hz_state, wait_cnt, stall_cnt, flush_cnt, mem_timeout; all update on the rising clk edge.
//  Async reset (rst_n=0) clears all registers immediately: hz_state=INIT, counters=0, mem_timeout=0.
//  hz_action is decided each cycle by the first matching rule, in priority order:
//   1 hz_state==INIT                     -> INIT (one hold cycle after reset release)
//   2 MEM_Req & ~MEM_Ready               -> MEM_WAIT
//   3 EX_BranchTaken                     -> FLUSH
//   4 lu = IDEX_MemRead & IDEX_Rt!=0 &
//        (IDEX_Rt==IFID_Rs | (IFID_UsesRt & IDEX_Rt==IFID_Rt)) -> LU_STALL
//   5 otherwise                          -> RUN
//  Output values for each action (PCWrite IFID_Write IFID_Flush IDEX_Bubble PipeFreeze):
//   INIT 0 0 0 1 1 | RUN 1 1 0 0 0 | LU_STALL 0 0 0 1 0 | FLUSH 1 1 1 1 0 | MEM_WAIT 0 0 0 0 1
//  Output timing:
//   - Outputs are combinational from hz_state and the inputs; zero latency to the pipeline registers.
//   - While rst_n=0, outputs take the INIT values.
//  Register update at each clock edge:
//   - hz_state <= hz_action.
//   - stall_cnt += 1 if the action is LU_STALL or MEM_WAIT; flush_cnt += 1 if the action is FLUSH.
//   - Both counters saturate at all-ones; no wrap-around.
//   - wait_cnt += 1 if the action is MEM_WAIT, else wait_cnt <= 0; it saturates at WAIT_TIMEOUT.
//   - mem_timeout <= 1 on the edge where wait_cnt reaches WAIT_TIMEOUT; it clears only on reset.
//  Boundary cases:
//   - MEM_WAIT suppresses a pending flush. EX is frozen, so EX_BranchTaken persists and the flush occurs on the first ready cycle.
//   - A branch and a load-use in the same cycle give FLUSH; the ID instruction is squashed, so no stall occurs.
//   - A load-use stall lasts exactly 1 cycle: the bubble clears IDEX_MemRead.
//   - Register $0 never causes a hazard.
//   - Reset asserted mid-stall or mid-wait aborts the stall or wait immediately; the next action after release is INIT.
// TESTING
//  T1 reset
//   - Stimulus: hold rst_n=0, then release.
//   - Required: during reset PCWrite=0, IFID_Write=0, IDEX_Bubble=1, PipeFreeze=1, counters=0.
//   - Required: the first cycle after release is INIT; the second edge gives RUN (PCWrite=1).
//  T2 load-use
//   - Stimulus: IDEX_MemRead=1, IDEX_Rt=5, IFID_Rs=5.
//   - Required: for one cycle PCWrite=0, IFID_Write=0, IDEX_Bubble=1, and stall_cnt goes 0->1.
//   - Stimulus: next cycle IDEX_MemRead=0.
//   - Required: RUN.
//  T3 no false stall
//   - Stimulus: IDEX_Rt=0 with IFID_Rs=0. Required: RUN.
//   - Stimulus: IDEX_Rt=7, IFID_Rt=7, IFID_UsesRt=0. Required: RUN.
//  T4 branch and load-use together
//   - Stimulus: EX_BranchTaken=1 together with the T2 load-use condition.
//   - Required: FLUSH with IFID_Flush=1, IDEX_Bubble=1, PCWrite=1; flush_cnt+1; stall_cnt unchanged.
//  T5 memory wait with pending branch
//   - Stimulus: MEM_Req=1, MEM_Ready=0 for 3 cycles, with EX_BranchTaken=1 throughout.
//   - Required: 3 cycles with PipeFreeze=1, IFID_Flush=0; stall_cnt+3.
//   - Stimulus: MEM_Ready=1.
//   - Required: FLUSH in that same cycle.
//  T6 timeout and saturation
//   - Stimulus: WAIT_TIMEOUT=4, 4 not-ready cycles.
//   - Required: mem_timeout=1 after the 4th edge and stays 1 after ready.
//   - Stimulus: CNT_W=4, 20 stall cycles.
//   - Required: stall_cnt=15.

Source files
------------

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline hazard sequencer: load-use stall, branch squash, memory-wait freeze
module hazard_control_unit #(
  parameter int REG_W        = 5,
  parameter int CNT_W        = 16,
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] IFID_Rs,
  input  logic [REG_W-1:0] IFID_Rt,
  input  logic             IFID_UsesRt,
  input  logic [REG_W-1:0] IDEX_Rt,
  input  logic             IDEX_MemRead,
  input  logic             EX_BranchTaken,
  input  logic             MEM_Req,
  input  logic             MEM_Ready,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic             PipeFreeze,
  output logic [2:0]       hz_action,
  output logic [2:0]       hz_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    RUN      = 3'd1,
    LU_STALL = 3'd2,
    FLUSH    = 3'd3,
    MEM_WAIT = 3'd4
  } action_t;

  localparam int              WAIT_W   = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_TIMEOUT);

  action_t           state_q;
  action_t           action;
  logic [WAIT_W-1:0] wait_cnt;
  logic              lu_hazard;

  assign lu_hazard = IDEX_MemRead && (IDEX_Rt != '0) &&
                     ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

  always_comb begin
    action = RUN;
    if (!rst_n || state_q == INIT)  action = INIT;
    else if (MEM_Req && !MEM_Ready) action = MEM_WAIT;
    else if (EX_BranchTaken)        action = FLUSH;
    else if (lu_hazard)             action = LU_STALL;
  end

  always_comb begin
    {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, PipeFreeze} = 5'b00011;
    case (action)
      RUN:      {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, PipeFreeze} = 5'b11000;
      LU_STALL: {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, PipeFreeze} = 5'b00010;
      FLUSH:    {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, PipeFreeze} = 5'b11110;
      MEM_WAIT: {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, PipeFreeze} = 5'b00001;
      default:  {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, PipeFreeze} = 5'b00011;
    endcase
  end

  assign hz_action = action;
  assign hz_state  = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      wait_cnt    <= '0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      // The INIT hold is recorded as RUN so that it lasts exactly one cycle.
      state_q <= (action == INIT) ? RUN : action;
      if ((action == LU_STALL || action == MEM_WAIT) && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (action == FLUSH && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
      if (action == MEM_WAIT) begin
        if (wait_cnt != WAIT_MAX)
          wait_cnt <= wait_cnt + WAIT_W'(1);
        if (wait_cnt == WAIT_MAX - WAIT_W'(1) || wait_cnt == WAIT_MAX)
          mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - self-checking bench for hazard_control_unit
module tb_hazard_control_unit;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;
  localparam int WT    = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [REG_W-1:0] ifid_rs, ifid_rt, idex_rt;
  logic ifid_uses_rt, idex_memread, br_taken, mem_req, mem_ready;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, mem_timeout;
  logic [2:0] hz_action, hz_state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit m_hold = 1'b1;
  int m_prev = 1;
  int m_stall = 0, m_flush = 0, m_wait = 0;
  bit m_to = 1'b0;

  hazard_control_unit #(.REG_W(REG_W), .CNT_W(CNT_W), .WAIT_TIMEOUT(WT)) dut (
    .clk(clk), .rst_n(rst_n),
    .IFID_Rs(ifid_rs), .IFID_Rt(ifid_rt), .IFID_UsesRt(ifid_uses_rt),
    .IDEX_Rt(idex_rt), .IDEX_MemRead(idex_memread), .EX_BranchTaken(br_taken),
    .MEM_Req(mem_req), .MEM_Ready(mem_ready),
    .PCWrite(pc_write), .IFID_Write(ifid_write), .IFID_Flush(ifid_flush),
    .IDEX_Bubble(idex_bubble), .PipeFreeze(pipe_freeze),
    .hz_action(hz_action), .hz_state(hz_state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_action();
    if (!rst_n || m_hold) return 0;
    if (mem_req && !mem_ready) return 4;
    if (br_taken) return 3;
    if (idex_memread && idex_rt != 0 &&
        (idex_rt == ifid_rs || (ifid_uses_rt && idex_rt == ifid_rt))) return 2;
    return 1;
  endfunction

  function automatic logic [4:0] exp_ctl(input int a);
    case (a)
      1:       return 5'b11000;
      2:       return 5'b00010;
      3:       return 5'b11110;
      4:       return 5'b00001;
      default: return 5'b00011;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold = 1'b1; m_prev = 1; m_stall = 0; m_flush = 0; m_wait = 0; m_to = 1'b0;
    end else begin
      int a;
      a = exp_action();
      m_hold = 1'b0;
      m_prev = (a == 0) ? 1 : a;
      if ((a == 2 || a == 4) && m_stall < CMAX) m_stall++;
      if (a == 3 && m_flush < CMAX) m_flush++;
      if (a == 4) begin
        if (m_wait < WT) m_wait++;
        if (m_wait == WT) m_to = 1'b1;
      end else begin
        m_wait = 0;
      end
    end
  end

  always @(negedge clk) begin
    int a;
    a = exp_action();
    chk("cmp_action", hz_action, a);
    chk("cmp_ctl", {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze}, exp_ctl(a));
    chk("cmp_state", hz_state, m_hold ? 0 : m_prev);
    chk("cmp_stall", stall_cnt, m_stall);
    chk("cmp_flush", flush_cnt, m_flush);
    chk("cmp_timeout", mem_timeout, m_to);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int burst;
    burst = 0;
    ifid_rs = 0; ifid_rt = 0; idex_rt = 0; ifid_uses_rt = 0; idex_memread = 0;
    br_taken = 0; mem_req = 0; mem_ready = 0;
    #1 rst_n = 1'b0;

    // T1 reset and release
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t1_rst_pcwrite", pc_write, 0);
    chk("t1_rst_ifid_write", ifid_write, 0);
    chk("t1_rst_bubble", idex_bubble, 1);
    chk("t1_rst_freeze", pipe_freeze, 1);
    chk("t1_rst_stall", stall_cnt, 0);
    chk("t1_rst_flush", flush_cnt, 0);
    step(); rst_n = 1'b1;
    @(negedge clk);
    chk("t1_first_init", hz_action, 0);
    chk("t1_first_pcwrite", pc_write, 0);
    step();
    @(negedge clk);
    chk("t1_run", hz_action, 1);
    chk("t1_run_pcwrite", pc_write, 1);

    // T2 load-use
    step(); idex_memread = 1; idex_rt = 5; ifid_rs = 5;
    @(negedge clk);
    chk("t2_action", hz_action, 2);
    chk("t2_pcwrite", pc_write, 0);
    chk("t2_ifid_write", ifid_write, 0);
    chk("t2_bubble", idex_bubble, 1);
    chk("t2_stall_before", stall_cnt, 0);
    step(); idex_memread = 0;
    @(negedge clk);
    chk("t2_after_run", hz_action, 1);
    chk("t2_stall_after", stall_cnt, 1);

    // T3 no false stall
    step(); idex_memread = 1; idex_rt = 0; ifid_rs = 0;
    @(negedge clk);
    chk("t3_reg0", hz_action, 1);
    step(); idex_rt = 7; ifid_rt = 7; ifid_rs = 3; ifid_uses_rt = 0;
    @(negedge clk);
    chk("t3_no_uses_rt", hz_action, 1);

    // T4 branch together with load-use
    step(); idex_rt = 5; ifid_rs = 5; br_taken = 1;
    @(negedge clk);
    chk("t4_action", hz_action, 3);
    chk("t4_ifid_flush", ifid_flush, 1);
    chk("t4_bubble", idex_bubble, 1);
    chk("t4_pcwrite", pc_write, 1);
    step(); br_taken = 0; idex_memread = 0;
    @(negedge clk);
    chk("t4_flush_cnt", flush_cnt, 1);
    chk("t4_stall_cnt", stall_cnt, 1);

    // T5 memory wait with pending branch
    step(); br_taken = 1; mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_wait_action", hz_action, 4);
      chk("t5_wait_freeze", pipe_freeze, 1);
      chk("t5_wait_no_flush", ifid_flush, 0);
      step();
    end
    mem_ready = 1;
    @(negedge clk);
    chk("t5_ready_flush", hz_action, 3);
    chk("t5_ready_ifid_flush", ifid_flush, 1);
    chk("t5_stall_cnt", stall_cnt, 4);
    step(); br_taken = 0; mem_req = 0;
    @(negedge clk);
    chk("t5_flush_cnt", flush_cnt, 2);

    // T6 timeout and saturation
    step(); mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_timeout_low", mem_timeout, 0);
      step();
    end
    mem_ready = 1;
    @(negedge clk);
    chk("t6_timeout_set", mem_timeout, 1);
    chk("t6_stall_cnt", stall_cnt, 8);
    step(); mem_ready = 0;
    repeat (20) @(posedge clk);
    #1 mem_ready = 1;
    @(negedge clk);
    chk("t6_stall_sat", stall_cnt, 15);
    chk("t6_timeout_sticky", mem_timeout, 1);

    // Reset in the middle of a memory wait
    step(); mem_ready = 0;
    @(negedge clk);
    chk("rw_wait", hz_action, 4);
    #1 rst_n = 1'b0;
    #1;
    chk("rw_action", hz_action, 0);
    chk("rw_stall", stall_cnt, 0);
    chk("rw_timeout", mem_timeout, 0);
    chk("rw_freeze", pipe_freeze, 1);
    step(); rst_n = 1'b1;
    @(negedge clk);
    chk("rw_init_over_wait", hz_action, 0);
    step(); mem_req = 0;
    @(negedge clk);
    chk("rw_run", hz_action, 1);

    // Randomized phase, checked by the model on every cycle
    for (int c = 0; c < 800; c++) begin
      step();
      rst_n = ($urandom_range(0, 149) != 0);
      ifid_rs = REG_W'($urandom_range(0, 3));
      ifid_rt = REG_W'($urandom_range(0, 3));
      idex_rt = REG_W'($urandom_range(0, 3));
      ifid_uses_rt = $urandom_range(0, 1) == 1;
      idex_memread = $urandom_range(0, 1) == 1;
      br_taken = $urandom_range(0, 4) == 0;
      if (burst == 0 && $urandom_range(0, 29) == 0) burst = $urandom_range(3, 8);
      mem_req = (burst > 0) || ($urandom_range(0, 2) == 0);
      mem_ready = (burst > 0) ? 1'b0 : ($urandom_range(0, 1) == 1);
      if (burst > 0) burst--;
    end
    step(); rst_n = 1'b1;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
